// File: rtl/tx_gearbox_6664.sv
// tx_gearbox_6664: packs one 66-bit block per cycle into a 64-bit word stream, pausing one cycle in every 33
module tx_gearbox_6664 (
  input  logic        i_txc,
  input  logic        i_reset,
  input  logic        i_init_done,
  input  logic [63:0] i_txd,
  input  logic [1:0]  i_tx_header,
  output logic        o_tx_pause,
  output logic [63:0] o_txd
);
  logic [5:0]   seq;
  logic [63:0]  residue;
  logic [127:0] wide;
  logic         drain;
  always_comb begin
    drain = seq == 6'd32;
    wide  = {62'b0, i_txd, i_tx_header} << {seq[4:0], 1'b0};
  end
  assign o_tx_pause = drain && i_init_done && !i_reset;
  always_ff @(posedge i_txc) begin
    if (i_reset || !i_init_done) begin
      seq     <= '0;
      residue <= '0;
      o_txd   <= '0;
    end else if (drain) begin
      seq     <= '0;
      residue <= '0;
      o_txd   <= residue;
    end else begin
      seq     <= seq + 6'd1;
      residue <= wide[127:64];
      o_txd   <= wide[63:0] | residue;
    end
  end
endmodule
